// File: rtl/pe_feeder.sv
// Operand feeder for one PE: holds a neuron's data/weight pairs, streams them
// back-to-back on start, waits out the PE latency and latches the result.
module pe_feeder #(
  parameter int INPUT_WIDTH    = 8,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int INPUT_NUM      = 32,
  parameter int PE_OUT_WIDTH   = 8,
  parameter int RESULT_LATENCY = 2,
  parameter int LOAD_WIDTH     = (INPUT_WIDTH > WEIGHT_WIDTH) ? INPUT_WIDTH : WEIGHT_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic                          load_sel,
  input  logic [$clog2(INPUT_NUM)-1:0]  load_addr,
  input  logic [LOAD_WIDTH-1:0]         load_value,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          new_weight,
  output logic                          input_available,
  output logic [INPUT_WIDTH-1:0]        input_data,
  output logic [WEIGHT_WIDTH-1:0]       weight,
  input  logic [PE_OUT_WIDTH-1:0]       pe_out,
  output logic [PE_OUT_WIDTH-1:0]       result,
  output logic                          result_valid
);

  localparam int ADDR_W  = $clog2(INPUT_NUM);
  localparam int BEAT_W  = $clog2(INPUT_NUM + 1);
  localparam int DRAIN_W = $clog2(RESULT_LATENCY + 1);
  localparam logic [ADDR_W:0]       NUM_A      = INPUT_NUM[ADDR_W:0];
  localparam logic [BEAT_W-1:0]     BEAT_END   = INPUT_NUM[BEAT_W-1:0];
  localparam logic [DRAIN_W-1:0]    DRAIN_INIT = RESULT_LATENCY[DRAIN_W-1:0];

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                    state, state_d;
  logic [BEAT_W-1:0]         beat_cnt, beat_d;
  logic [DRAIN_W-1:0]        drain_cnt, drain_d;
  logic                      busy_d, done_d, nw_d, ia_d, rv_d;
  logic [INPUT_WIDTH-1:0]    idata_d;
  logic [WEIGHT_WIDTH-1:0]   wt_d;
  logic [PE_OUT_WIDTH-1:0]   result_d;

  logic [INPUT_WIDTH-1:0]    data_mem   [INPUT_NUM];
  logic [WEIGHT_WIDTH-1:0]   weight_mem [INPUT_NUM];

  // A load coinciding with start is written at once; the overwritten entry is
  // kept here so the run that just began still streams the old operand.
  logic                      sh_vld, sh_sel;
  logic [ADDR_W-1:0]         sh_addr;
  logic [INPUT_WIDTH-1:0]    sh_data;
  logic [WEIGHT_WIDTH-1:0]   sh_wt;

  logic                      start_acc, load_ok;
  logic [ADDR_W-1:0]         beat_idx;
  logic [INPUT_WIDTH-1:0]    beat_data;
  logic [WEIGHT_WIDTH-1:0]   beat_wt;

  assign start_acc = start && (state == IDLE);
  assign load_ok   = load_en && (state == IDLE) && ({1'b0, load_addr} < NUM_A);
  assign beat_idx  = beat_cnt[ADDR_W-1:0];

  always_comb begin
    beat_data = data_mem[beat_idx];
    beat_wt   = weight_mem[beat_idx];
    if (sh_vld && (sh_addr == beat_idx)) begin
      if (sh_sel) beat_wt   = sh_wt;
      else        beat_data = sh_data;
    end
  end

  always_ff @(posedge clk) begin
    if (load_ok) begin
      if (load_sel) weight_mem[load_addr] <= load_value[WEIGHT_WIDTH-1:0];
      else          data_mem[load_addr]   <= load_value[INPUT_WIDTH-1:0];
    end
    if (start_acc) begin
      sh_sel  <= load_sel;
      sh_addr <= load_addr;
      sh_data <= data_mem[load_addr];
      sh_wt   <= weight_mem[load_addr];
    end
  end

  always_comb begin
    state_d  = state;
    beat_d   = beat_cnt;
    drain_d  = drain_cnt;
    busy_d   = busy;
    done_d   = 1'b0;
    nw_d     = 1'b0;
    ia_d     = 1'b0;
    idata_d  = '0;
    wt_d     = '0;
    result_d = result;
    rv_d     = result_valid;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          beat_d  = BEAT_W'(1);
          busy_d  = 1'b1;
          rv_d    = 1'b0;
          nw_d    = 1'b1;
          ia_d    = 1'b1;
          idata_d = data_mem[0];
          wt_d    = weight_mem[0];
        end
      end
      STREAM: begin
        if (beat_cnt == BEAT_END) begin
          state_d = DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          nw_d    = 1'b1;
          ia_d    = 1'b1;
          idata_d = beat_data;
          wt_d    = beat_wt;
          beat_d  = beat_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_W'(1)) begin
          state_d  = IDLE;
          drain_d  = '0;
          beat_d   = '0;
          result_d = pe_out;
          rv_d     = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end else begin
          drain_d = drain_cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      beat_cnt        <= '0;
      drain_cnt       <= '0;
      sh_vld          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      new_weight      <= 1'b0;
      input_available <= 1'b0;
      input_data      <= '0;
      weight          <= '0;
      result          <= '0;
      result_valid    <= 1'b0;
    end else begin
      state           <= state_d;
      beat_cnt        <= beat_d;
      drain_cnt       <= drain_d;
      if (start_acc) sh_vld <= load_ok;
      busy            <= busy_d;
      done            <= done_d;
      new_weight      <= nw_d;
      input_available <= ia_d;
      input_data      <= idata_d;
      weight          <= wt_d;
      result          <= result_d;
      result_valid    <= rv_d;
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: schedule-based reference model checked every cycle,
// plus directed literal expectations and a small second instance.
module tb_pe_feeder;
  localparam int N = 32;
  localparam int L = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       load_en = 1'b0, load_sel = 1'b0, start = 1'b0;
  logic [4:0] load_addr = '0;
  logic [7:0] load_value = '0, pe_out = '0;
  logic       busy, done, new_weight, input_available, result_valid;
  logic [7:0] input_data, weight, result;

  logic       l2_en = 1'b0, l2_sel = 1'b0, st2 = 1'b0;
  logic [2:0] l2_addr = '0;
  logic [7:0] l2_val = '0, pe2 = '0;
  logic       b2, dn2, nw2, ia2, rv2;
  logic [7:0] id2, w2, r2;

  int checks = 0;
  int failures = 0;

  pe_feeder #(.INPUT_NUM(N), .RESULT_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_sel(load_sel),
    .load_addr(load_addr), .load_value(load_value), .start(start),
    .busy(busy), .done(done), .new_weight(new_weight),
    .input_available(input_available), .input_data(input_data),
    .weight(weight), .pe_out(pe_out), .result(result), .result_valid(result_valid));

  pe_feeder #(.INPUT_NUM(6), .RESULT_LATENCY(1)) dut2 (
    .clk(clk), .reset(reset), .load_en(l2_en), .load_sel(l2_sel),
    .load_addr(l2_addr), .load_value(l2_val), .start(st2),
    .busy(b2), .done(dn2), .new_weight(nw2),
    .input_available(ia2), .input_data(id2),
    .weight(w2), .pe_out(pe2), .result(r2), .result_valid(rv2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a run is a schedule of edges counted from the accepted
  // start; the operand arrays are snapshotted when the run begins.
  logic [7:0] m_data [N];
  logic [7:0] m_wt   [N];
  logic [7:0] s_data [N];
  logic [7:0] s_wt   [N];
  int         phase = -1;
  logic       e_busy = 0, e_done = 0, e_nw = 0, e_ia = 0, e_rv = 0;
  logic [7:0] e_id = 0, e_w = 0, e_res = 0;

  initial begin
    for (int i = 0; i < N; i++) begin m_data[i] = 0; m_wt[i] = 0; end
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        phase = -1;
        {e_busy, e_done, e_nw, e_ia, e_rv} = '0;
        e_id = 0; e_w = 0; e_res = 0;
      end else begin
        automatic bit idle = (phase < 0);
        e_done = 0;
        if (idle && start) begin
          s_data = m_data; s_wt = m_wt;
          phase = 0; e_busy = 1; e_rv = 0;
        end else if (!idle) begin
          phase++;
        end
        if (idle && load_en && int'(load_addr) < N) begin
          if (load_sel) m_wt[load_addr] = load_value;
          else          m_data[load_addr] = load_value;
        end
        if (phase >= 0 && phase < N) begin
          e_nw = 1; e_ia = 1; e_id = s_data[phase]; e_w = s_wt[phase];
        end else begin
          e_nw = 0; e_ia = 0; e_id = 0; e_w = 0;
        end
        if (phase == N + L) begin
          e_res = pe_out; e_rv = 1; e_done = 1; e_busy = 0; phase = -1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cycle", 32'({busy, done, new_weight, input_available, input_data, weight, result, result_valid}),
                   32'({e_busy, e_done, e_nw, e_ia, e_id, e_w, e_res, e_rv}));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'({busy, done, new_weight, input_available, input_data, weight, result, result_valid}), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < N; i++) begin
      load_en = 1; load_sel = 0; load_addr = 5'(i); load_value = 8'(i);
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) begin
      load_en = 1; load_sel = 1; load_addr = 5'(i); load_value = 8'(8'h40 - i);
      @(negedge clk);
    end
    load_en = 0;
    pe_out = 8'h11;

    // Run 1 begins at edge T; run 2 at T+35 and is reset at its beat 10.
    start = 1;
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      start = 0; load_en = 0;
      case (k)
        0: begin
          chk("b0_data", 32'(input_data), 32'h00);
          chk("b0_wt", 32'(weight), 32'h40);
          chk("b0_vld", 32'({input_available, new_weight, busy}), 32'h7);
        end
        3: begin
          chk("b3_data", 32'(input_data), 32'h03);
          chk("b3_wt", 32'(weight), 32'h3D);
        end
        5:  chk("b5_data", 32'(input_data), 32'h05);
        6:  chk("b6_data", 32'(input_data), 32'h06);
        31: begin
          chk("b31_vld", 32'({input_available, new_weight}), 32'h3);
          chk("b31_data", 32'(input_data), 32'h1F);
          chk("b31_wt", 32'(weight), 32'h21);
        end
        32: begin
          chk("end_beats", 32'({input_available, new_weight, input_data, weight}), 32'h0);
          chk("drain_busy", 32'(busy), 32'h1);
        end
        33: chk("pre_done", 32'({done, busy}), 32'h1);
        34: begin
          chk("done_pulse", 32'({done, busy, result_valid}), 32'h5);
          chk("result", 32'(result), 32'h5A);
        end
        35: begin
          chk("restart", 32'({done, busy, result_valid, input_available}), 32'h5);
          chk("restart_d0", 32'(input_data), 32'h00);
        end
        42: chk("r2_b7", 32'(input_data), 32'h07);
        45: chk("r2_b10", 32'(input_data), 32'h0A);
        default: ;
      endcase
      if (k + 1 == 3) begin load_en = 1; load_sel = 0; load_addr = 0; load_value = 8'hFF; end
      if (k + 1 == 5 || k + 1 == 34) start = 1;
      if (k + 1 == 35) begin
        start = 1; load_en = 1; load_sel = 0; load_addr = 5'd7; load_value = 8'h77;
      end
      if (k + 1 >= 32) pe_out = 8'h5A;
    end

    #2 reset = 1'b0;
    #1 chk("rst_async", 32'({busy, done, new_weight, input_available, input_data, weight, result, result_valid}), 32'h0);
    @(negedge clk);
    chk("rst_no_done", 32'({done, result_valid}), 32'h0);
    reset = 1'b1;
    pe_out = 8'hA5;
    @(negedge clk);

    start = 1;
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      start = 0;
      case (k)
        0: begin
          chk("r3_b0", 32'({input_available, input_data, weight}), 32'h10040);
        end
        7:  chk("r3_b7_loaded", 32'(input_data), 32'h77);
        10: chk("r3_b10_wt", 32'(weight), 32'h36);
        34: begin
          chk("r3_done", 32'({done, busy, result_valid}), 32'h5);
          chk("r3_result", 32'(result), 32'hA5);
        end
        default: ;
      endcase
    end

    // Second instance: 6 pairs, latency 1, out-of-range loads to 6 and 7.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      l2_en = 1; l2_sel = 0; l2_addr = 3'(i); l2_val = (i < 6) ? 8'(8'h10 + i) : 8'hEE;
      @(negedge clk);
      l2_sel = 1; l2_val = (i < 6) ? 8'(8'h80 + i) : 8'hEE;
    end
    @(negedge clk);
    l2_en = 0; pe2 = 8'h3C;
    st2 = 1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      st2 = 0;
      if (k < 6) begin
        chk("d2_beat", 32'({ia2, id2, w2}), 32'({1'b1, 8'(8'h10 + k), 8'(8'h80 + k)}));
      end else if (k == 6) begin
        chk("d2_drain", 32'({ia2, nw2, b2, dn2}), 32'h2);
      end else begin
        chk("d2_done", 32'({dn2, b2, rv2, r2}), 32'({3'b101, 8'h3C}));
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
